// File: rtl/vga_frame_sync_ctrl.sv
// vga_frame_sync_ctrl
//   Tear-free register scheduler between the processor register file and
//   the VGA display path. Processor writes land in a pending bank; a commit
//   request copies the whole pending bank into the active bank in one cycle
//   at the next frame boundary (screen_end), so every frame is drawn from a
//   single coherent snapshot.
//
//   Optional feature: define VGA_FRAME_COUNT_EN to enable a free-running
//   frame counter on frame_count. Undefined, frame_count is tied to zero.
module vga_frame_sync_ctrl #(
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int FC_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     screen_end,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     commit_req,
  output logic                     wr_ready,
  output logic                     pending,
  output logic                     commit_ack,
  output logic                     addr_err,
  output logic [NUM_REGS*32-1:0]   active_regs,
  output logic [FC_W-1:0]          frame_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Register count widened by one bit so it can be compared against wr_addr
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  state_t              state_reg;
  state_t              state_next;
  logic                do_commit;
  logic                wr_accept;
  logic                addr_ok;
  logic [NUM_REGS-1:0] wr_hit;
  logic                commit_ack_reg;
  logic                addr_err_reg;

  // A write is taken whenever the bank is not being copied; range is checked separately
  assign wr_accept = wr_en & wr_ready;
  assign addr_ok   = ({1'b0, wr_addr} < NUM_REGS_W);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and status decode; the copy fires on the PENDING->COMMIT edge
  // so the new snapshot is already visible during the COMMIT cycle
  always_comb begin
    state_next = state_reg;
    wr_ready   = 1'b1;
    pending    = 1'b0;
    do_commit  = 1'b0;
    case (state_reg)
      IDLE: begin
        // A coincident screen_end is deliberately ignored: the copy must wait a full frame
        if (commit_req) state_next = PENDING;
      end
      PENDING: begin
        pending = 1'b1;
        if (screen_end) begin
          state_next = COMMIT;
          do_commit  = 1'b1;
        end
      end
      COMMIT: begin
        wr_ready   = 1'b0;
        state_next = commit_req ? PENDING : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Acknowledge the copy one cycle after COMMIT; flag out-of-range writes one cycle late
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_ack_reg <= 1'b0;
      addr_err_reg   <= 1'b0;
    end else begin
      commit_ack_reg <= (state_reg == COMMIT);
      addr_err_reg   <= wr_accept & ~addr_ok;
    end
  end

  assign commit_ack = commit_ack_reg;
  assign addr_err   = addr_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi = gi + 1) begin : g_reg
      logic [31:0] pend_reg;
      logic [31:0] active_reg;

      assign wr_hit[gi] = wr_accept & addr_ok & (wr_addr == ADDR_W'(gi));

      // Pending bank: holds the latest processor write until reset
      always_ff @(posedge clk or posedge reset) begin
        if (reset)           pend_reg <= '0;
        else if (wr_hit[gi]) pend_reg <= wr_data;
      end

      // Active bank: snapshot of the pending bank, with a same-cycle write forwarded in
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          active_reg <= '0;
        else if (do_commit) active_reg <= wr_hit[gi] ? wr_data : pend_reg;
      end

      assign active_regs[32*gi +: 32] = active_reg;
    end
  endgenerate

`ifdef VGA_FRAME_COUNT_EN
  logic [FC_W-1:0] frame_count_reg;

  // Free-running frame counter, independent of commit activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           frame_count_reg <= '0;
    else if (screen_end) frame_count_reg <= frame_count_reg + 1'b1;
  end

  assign frame_count = frame_count_reg;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_frame_sync_ctrl.sv
// Directed testbench for vga_frame_sync_ctrl. Inputs are driven 1 ns after
// each rising edge and outputs are sampled at the same point, so every
// observation reflects the result of the preceding edge.
module tb_vga_frame_sync_ctrl;

  localparam int NUM_REGS = 15;
  localparam int ADDR_W   = 4;
  localparam int FC_W     = 4;

  logic                   clk;
  logic                   reset;
  logic                   screen_end;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [31:0]            wr_data;
  logic                   commit_req;
  logic                   wr_ready;
  logic                   pending;
  logic                   commit_ack;
  logic                   addr_err;
  logic [NUM_REGS*32-1:0] active_regs;
  logic [FC_W-1:0]        frame_count;

  int checks;
  int failures;

  vga_frame_sync_ctrl #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .FC_W    (FC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .screen_end (screen_end),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit_req (commit_req),
    .wr_ready   (wr_ready),
    .pending    (pending),
    .commit_ack (commit_ack),
    .addr_err   (addr_err),
    .active_regs(active_regs),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] areg(input int i);
    return active_regs[32*i +: 32];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b want=0", pending); end
    checks++; if (commit_ack !== 1'b0) begin failures++; $display("FAIL reset_commit_ack got=%b want=0", commit_ack); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err got=%b want=0", addr_err); end
    checks++; if (active_regs !== '0) begin failures++; $display("FAIL reset_active got=%h want=0", active_regs); end
    checks++; if (frame_count !== '0) begin failures++; $display("FAIL reset_frame_count got=%0d want=0", frame_count); end
    $display("test_reset done checks=%0d", checks);
  endtask

  // T1: writes without commit never reach the active bank
  task automatic test_no_commit;
    do_write(4'd0, 32'd100);
    do_write(4'd12, 32'd200);
    for (int k = 0; k < 3; k++) begin
      screen_end = 1'b1; tick(); screen_end = 1'b0;
      checks++; if (active_regs !== '0) begin failures++; $display("FAIL nocommit_active frame=%0d got=%h want=0", k, active_regs); end
      checks++; if (pending !== 1'b0) begin failures++; $display("FAIL nocommit_pending frame=%0d got=%b want=0", k, pending); end
      tick();
    end
    $display("test_no_commit done checks=%0d", checks);
  endtask

  // T2: commit waits 10 cycles for screen_end, then copies in one cycle
  task automatic test_commit;
    do_write(4'd13, 32'd5);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (pending !== 1'b1) begin failures++; $display("FAIL commit_pending cyc=%0d got=%b want=1", k, pending); end
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL commit_wr_ready_pre cyc=%0d got=%b want=1", k, wr_ready); end
      checks++; if (areg(13) !== 32'd0) begin failures++; $display("FAIL commit_early_copy cyc=%0d got=%0d want=0", k, areg(13)); end
      if (k == 9) screen_end = 1'b1;
      tick();
    end
    screen_end = 1'b0;
    // COMMIT cycle
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL commit_wr_ready got=%b want=0", wr_ready); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL commit_pending_drop got=%b want=0", pending); end
    checks++; if (areg(13) !== 32'd5) begin failures++; $display("FAIL commit_reg13 got=%0d want=5", areg(13)); end
    checks++; if (areg(0) !== 32'd100) begin failures++; $display("FAIL commit_reg0 got=%0d want=100", areg(0)); end
    checks++; if (areg(12) !== 32'd200) begin failures++; $display("FAIL commit_reg12 got=%0d want=200", areg(12)); end
    checks++; if (commit_ack !== 1'b0) begin failures++; $display("FAIL commit_ack_early got=%b want=0", commit_ack); end
    tick();
    checks++; if (commit_ack !== 1'b1) begin failures++; $display("FAIL commit_ack got=%b want=1", commit_ack); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL commit_wr_ready_post got=%b want=1", wr_ready); end
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL commit_idle got=%b want=0", pending); end
    tick();
    checks++; if (commit_ack !== 1'b0) begin failures++; $display("FAIL commit_ack_width got=%b want=0", commit_ack); end
    $display("test_commit done checks=%0d", checks);
  endtask

  // T3: commit_req coincident with screen_end defers to the next frame;
  // a write on the PENDING->COMMIT cycle lands in the snapshot
  task automatic test_same_cycle;
    do_write(4'd2, 32'd33);
    commit_req = 1'b1; screen_end = 1'b1; tick();
    commit_req = 1'b0; screen_end = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL same_pending got=%b want=1", pending); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL same_no_commit got=%b want=1", wr_ready); end
    checks++; if (areg(2) !== 32'd0) begin failures++; $display("FAIL same_reg2_early got=%0d want=0", areg(2)); end
    tick(); tick();
    screen_end = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd44;
    tick();
    screen_end = 1'b0; wr_en = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL same_commit got=%b want=0", wr_ready); end
    checks++; if (areg(2) !== 32'd33) begin failures++; $display("FAIL same_reg2 got=%0d want=33", areg(2)); end
    checks++; if (areg(3) !== 32'd44) begin failures++; $display("FAIL same_edge_write got=%0d want=44", areg(3)); end
    tick();
    checks++; if (commit_ack !== 1'b1) begin failures++; $display("FAIL same_ack got=%b want=1", commit_ack); end
    tick();
    $display("test_same_cycle done checks=%0d", checks);
  endtask

  // T4: write during COMMIT is dropped; out-of-range write flags addr_err only
  task automatic test_drop_and_err;
    logic [NUM_REGS*32-1:0] exp;
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    screen_end = 1'b1; tick(); screen_end = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL drop_in_commit got=%b want=0", wr_ready); end
    do_write(4'd1, 32'd7);
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL drop_no_err got=%b want=0", addr_err); end
    do_write(4'd15, 32'd99);
    checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL addr_err_pulse got=%b want=1", addr_err); end
    tick();
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL addr_err_width got=%b want=0", addr_err); end
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    screen_end = 1'b1; tick(); screen_end = 1'b0;
    exp = '0;
    exp[32*0  +: 32] = 32'd100;
    exp[32*2  +: 32] = 32'd33;
    exp[32*3  +: 32] = 32'd44;
    exp[32*12 +: 32] = 32'd200;
    exp[32*13 +: 32] = 32'd5;
    checks++; if (areg(1) !== 32'd0) begin failures++; $display("FAIL drop_reg1 got=%0d want=0", areg(1)); end
    checks++; if (active_regs !== exp) begin failures++; $display("FAIL drop_bank got=%h want=%h", active_regs, exp); end
    tick(); tick();
    $display("test_drop_and_err done checks=%0d", checks);
  endtask

  // commit_req during COMMIT re-arms; repeated commit_req in PENDING is merged
  task automatic test_rearm;
    commit_req = 1'b1; tick();
    tick();                       // still requesting while PENDING
    screen_end = 1'b1; tick(); screen_end = 1'b0;
    // COMMIT cycle with commit_req still high
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rearm_commit got=%b want=0", wr_ready); end
    tick(); commit_req = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL rearm_pending got=%b want=1", pending); end
    checks++; if (commit_ack !== 1'b1) begin failures++; $display("FAIL rearm_ack got=%b want=1", commit_ack); end
    do_write(4'd14, 32'd77);
    screen_end = 1'b1; tick(); screen_end = 1'b0;
    checks++; if (areg(14) !== 32'd77) begin failures++; $display("FAIL rearm_reg14 got=%0d want=77", areg(14)); end
    tick(); tick();
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rearm_merged got=%b want=0", pending); end
    screen_end = 1'b1; tick(); screen_end = 1'b0;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rearm_no_extra got=%b want=1", wr_ready); end
    tick();
    $display("test_rearm done checks=%0d", checks);
  endtask

  // T5: reset during PENDING clears everything at once and cancels the commit
  task automatic test_reset_mid;
    do_write(4'd5, 32'd55);
    commit_req = 1'b1; tick(); commit_req = 1'b0;
    checks++; if (pending !== 1'b1) begin failures++; $display("FAIL mid_pending_pre got=%b want=1", pending); end
    reset = 1'b1;
    #1;
    checks++; if (pending !== 1'b0) begin failures++; $display("FAIL mid_pending got=%b want=0", pending); end
    checks++; if (active_regs !== '0) begin failures++; $display("FAIL mid_active got=%h want=0", active_regs); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL mid_wr_ready got=%b want=1", wr_ready); end
    tick();
    reset = 1'b0;
    tick();
    screen_end = 1'b1; tick(); screen_end = 1'b0;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL mid_no_commit got=%b want=1", wr_ready); end
    checks++; if (areg(5) !== 32'd0) begin failures++; $display("FAIL mid_reg5 got=%0d want=0", areg(5)); end
    tick();
    checks++; if (commit_ack !== 1'b0) begin failures++; $display("FAIL mid_no_ack got=%b want=0", commit_ack); end
    $display("test_reset_mid done checks=%0d", checks);
  endtask

  // T6: 17 frames on a 4-bit counter wraps to 1 (or stays 0 when disabled)
  task automatic test_frame_count;
    logic [FC_W-1:0] want;
`ifdef VGA_FRAME_COUNT_EN
    want = 4'd1;
`else
    want = 4'd0;
`endif
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      screen_end = 1'b1; tick(); screen_end = 1'b0; tick();
    end
    checks++; if (frame_count !== want) begin failures++; $display("FAIL frame_count got=%0d want=%0d", frame_count, want); end
    $display("test_frame_count done checks=%0d", checks);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; screen_end = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; commit_req = 1'b0;
    test_reset();
    test_no_commit();
    test_commit();
    test_same_cycle();
    test_drop_and_err();
    test_rearm();
    test_reset_mid();
    test_frame_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
